data_memory_mmio: RTL and testbench
===================================

# data_memory_mmio

Parametrised data memory for the single-cycle CPU with byte/halfword/word loads and stores, sign/zero extension, misalignment detection, and a memory-mapped I/O page that holds an interval timer and an LED register. It replaces the word-only data memory in the MEM stage. Read data is combinational so the single-cycle datapath is unchanged. Writes and all register updates commit on the clock edge.

## Interface
Parameters:
- ADDR_BITS, default 8: word-address bits, giving 2^ADDR_BITS RAM words (256 words = 1 KiB).
- MMIO_PAGE, default 4'h4: value of addr[31:28] that selects the MMIO page.

Ports:
- clk  input  1: clock; all state updates on the rising edge.
- reset  input  1: asynchronous, active-high.
- addr  input  32: byte address.
- wdata  input  32: store data, right-aligned (the byte is in [7:0], the half in [15:0]).
- mem_read  input  1: load strobe.
- mem_write  input  1: store strobe.
- size  input  2: access size. 00 is byte, 01 is half, 10 is word, 11 is reserved and treated as word.
- unsigned_ld  input  1: selects zero extension for byte and half loads; 0 selects sign extension.
- rdata  output  32: load result; 0 when mem_read=0.
- misalign  output  1: access fault flag, combinational.
- led  output  8: LED register.
- irq  output  1: timer interrupt request, equal to TCON[1] & TCON[2].

## Operation
- **Region decode.**
  - addr[31:28]==MMIO_PAGE selects MMIO. Any other value selects RAM.
  - RAM word index is addr[ADDR_BITS+1:2]. Higher address bits are ignored, so the RAM aliases.
- **Byte lanes.** Little-endian: the byte at addr[1:0]=k occupies bits [8k+7:8k].
- **Misalignment.** misalign=1 when (mem_read|mem_write) and any of the following holds:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - any non-word access to the MMIO page.

  When misalign=1, the store is suppressed and rdata=0.
- **Loads.**
  - The selected byte or half is extended to 32 bits: sign-extended if unsigned_ld=0, zero-extended if unsigned_ld=1.
  - A word load returns the stored word as is.
- **Stores.** Only the addressed lanes are written. The byte is taken from wdata[7:0], the half from wdata[15:0], the word from wdata[31:0].
- **MMIO map** (word access only):
  - +0x0 TH: timer reload value, read/write.
  - +0x4 TL: timer counter, read/write.
  - +0x8 TCON: read/write, bits [2:0] only; upper bits read 0.
    - bit0: count enable.
    - bit1: irq enable.
    - bit2: irq status.
  - +0xC LED: read/write; low 8 bits drive led, upper bits read 0.
  - Other offsets read 0; writes to them are ignored.
- **Timer.** On each rising edge with TCON[0]=1:
  - If TL==32'hFFFFFFFF: TL<=TH, and if TCON[1]=1 then TCON[2]<=1.
  - Otherwise TL<=TL+1 (mod 2^32).
- **Priority in one cycle.**
  - A CPU write to TL overrides that cycle's count or reload.
  - A CPU write to TCON loads bits [2:0]. If an overflow with irq enable happens in the same cycle, TCON[2] is still set (OR).
  - The CPU clears the interrupt by writing TCON[2]=0.
- **Reset.** Asynchronously clears:
  - all RAM words;
  - TH, TL, TCON and LED.

  After reset: rdata=0 (mem_read=0), misalign=0, led=0, irq=0. Reset asserted mid-count stops the timer immediately.

## Timing
- rdata and misalign are combinational from addr, size, unsigned_ld, mem_read, mem_write and the current state. Load latency is zero cycles.
- Stores and MMIO writes are visible to a load in the cycle after the write edge.
- The timer counts on every edge after the edge that writes TCON[0]=1. The first increment occurs on the next edge.
- TCON[2] and irq rise on the edge on which TL wraps (the reload edge). irq is registered-derived and glitch-free.
- led updates on the write edge.

## Test plan
- **Load extension.** Reset, then sw 0x80FF7F01 to 0x10. Required results:
  - lw 0x10 gives 0x80FF7F01;
  - lb 0x12 gives 0xFFFFFFFF; lbu 0x12 gives 0x000000FF;
  - lb 0x11 gives 0x0000007F;
  - lh 0x12 gives 0xFFFF80FF; lhu 0x12 gives 0x000080FF.
- **Byte store.** sw 0 to 0x20, then sb wdata=0x123456AB to 0x21. Required: lw 0x20 gives 0x0000AB00. Then sh 0xBEEF to 0x22; required: lw 0x20 gives 0xBEEFAB00.
- **Misalignment.** Each of the following asserts misalign=1 in its cycle, leaves memory unchanged and returns rdata=0:
  - sw 0xFFFFFFFF to 0x22; lw 0x20 still gives 0xBEEFAB00;
  - lh 0x23;
  - sb to 0x40000000.
- **Timer overflow.** Set TH=0xFFFFFFFD, TL=0xFFFFFFFD, then TCON=3. Required:
  - on the next three edges TL reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0xFFFFFFFD;
  - irq rises on the third edge;
  - writing TCON=3 clears irq on the following edge.
- **Write collision and aliasing.**
  - Write TL=0x5 on the edge where TL==0xFFFFFFFF with the timer enabled: TL reads 0x5, TCON[2] is set.
  - With ADDR_BITS=8, sw 0xA5A5A5A5 to 0x400: lw 0x000 gives 0xA5A5A5A5.
- **LED and mid-run reset.** sw 0x000001A5 to 0x4000000C: led=0xA5, lw reads 0xA5. Assert reset mid-count: TL, TCON, led and irq are 0 immediately, and lw 0x10 gives 0.

Source files
------------

// File: rtl/data_memory_mmio_if.sv
// Bus between the MEM stage and the data memory: address, store data,
// strobes and access size towards the memory; load data and fault back.
interface data_memory_mmio_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] rdata;
    logic        misalign;

    modport master (
        output addr, wdata, mem_read, mem_write, size, unsigned_ld,
        input  rdata, misalign
    );

    modport slave (
        input  addr, wdata, mem_read, mem_write, size, unsigned_ld,
        output rdata, misalign
    );
endinterface

// File: rtl/data_memory_mmio.sv
// Data memory for the single-cycle CPU: byte/half/word access with
// sign/zero extension, misalignment detection, and an MMIO page holding an
// interval timer (TH/TL/TCON) and an LED register. Loads are combinational,
// all state commits on the rising clock edge.
module data_memory_mmio #(
    parameter int       ADDR_BITS = 8,
    parameter bit [3:0] MMIO_PAGE = 4'h4
) (
    input  logic                clk,
    input  logic                reset,
    data_memory_mmio_if.slave   bus,
    output logic [7:0]          led,
    output logic                irq
);
    localparam int NUM_WORDS = 1 << ADDR_BITS;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    localparam logic [27:0] OFF_TH   = 28'h0;
    localparam logic [27:0] OFF_TL   = 28'h4;
    localparam logic [27:0] OFF_TCON = 28'h8;
    localparam logic [27:0] OFF_LED  = 28'hC;

    logic [31:0] ram [NUM_WORDS];
    logic [31:0] th_q;
    logic [31:0] tl_q;
    logic [2:0]  tcon_q;
    logic [7:0]  led_q;

    logic                 is_mmio;
    logic                 is_byte;
    logic                 is_half;
    logic                 is_word;
    logic                 access;
    logic                 fault;
    logic [ADDR_BITS-1:0] word_idx;
    logic [31:0]          ram_word;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [31:0]          mmio_rd;
    logic [31:0]          load_val;
    logic [3:0]           lane_en;
    logic [31:0]          lane_data;
    logic                 ram_we;
    logic                 mmio_we;
    logic                 wr_th;
    logic                 wr_tl;
    logic                 wr_tcon;
    logic                 wr_led;
    logic                 wrap;
    logic                 set_status;

    // Address decode and access classification; size 11 behaves as word.
    always_comb begin
        is_mmio  = (bus.addr[31:28] == MMIO_PAGE);
        is_byte  = (bus.size == SZ_BYTE);
        is_half  = (bus.size == SZ_HALF);
        is_word  = !is_byte && !is_half;
        access   = bus.mem_read || bus.mem_write;
        fault    = access && ((is_half && bus.addr[0])
                           || (is_word && (bus.addr[1:0] != 2'b00))
                           || (is_mmio && !is_word));
        word_idx = bus.addr[ADDR_BITS+1:2];
        ram_word = ram[word_idx];
    end

    // Lane extraction from the addressed RAM word (little-endian).
    always_comb begin
        case (bus.addr[1:0])
            2'd0:    ld_byte = ram_word[7:0];
            2'd1:    ld_byte = ram_word[15:8];
            2'd2:    ld_byte = ram_word[23:16];
            default: ld_byte = ram_word[31:24];
        endcase
        ld_half = bus.addr[1] ? ram_word[31:16] : ram_word[15:0];
    end

    // MMIO register read mux; unmapped offsets read zero.
    always_comb begin
        case (bus.addr[27:0])
            OFF_TH:   mmio_rd = th_q;
            OFF_TL:   mmio_rd = tl_q;
            OFF_TCON: mmio_rd = {29'd0, tcon_q};
            OFF_LED:  mmio_rd = {24'd0, led_q};
            default:  mmio_rd = 32'd0;
        endcase
    end

    // Load result with extension; zero when not reading or on a fault.
    always_comb begin
        load_val = 32'd0;
        if (is_mmio) begin
            load_val = mmio_rd;
        end else if (is_byte) begin
            load_val = bus.unsigned_ld ? {24'd0, ld_byte}
                                       : {{24{ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            load_val = bus.unsigned_ld ? {16'd0, ld_half}
                                       : {{16{ld_half[15]}}, ld_half};
        end else begin
            load_val = ram_word;
        end
        bus.rdata    = (bus.mem_read && !fault) ? load_val : 32'd0;
        bus.misalign = fault;
    end

    // Store lane enables and replicated store data; faults suppress writes.
    always_comb begin
        lane_en   = 4'b0000;
        lane_data = bus.wdata;
        if (is_byte) begin
            lane_en   = 4'b0001 << bus.addr[1:0];
            lane_data = {4{bus.wdata[7:0]}};
        end else if (is_half) begin
            lane_en   = bus.addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{bus.wdata[15:0]}};
        end else begin
            lane_en   = 4'b1111;
        end
        ram_we  = bus.mem_write && !fault && !is_mmio;
        mmio_we = bus.mem_write && !fault && is_mmio;
        wr_th   = mmio_we && (bus.addr[27:0] == OFF_TH);
        wr_tl   = mmio_we && (bus.addr[27:0] == OFF_TL);
        wr_tcon = mmio_we && (bus.addr[27:0] == OFF_TCON);
        wr_led  = mmio_we && (bus.addr[27:0] == OFF_LED);
    end

    // Timer wrap detection; status sets only when irq enable is already on.
    always_comb begin
        wrap       = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
        set_status = wrap && tcon_q[1];
    end

    // RAM array: cleared on reset, lane-masked writes otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                ram[i] <= 32'd0;
            end
        end else if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    ram[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
        end
    end

    // Timer reload register and LED register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q  <= 32'd0;
            led_q <= 8'd0;
        end else begin
            if (wr_th) begin
                th_q <= bus.wdata;
            end
            if (wr_led) begin
                led_q <= bus.wdata[7:0];
            end
        end
    end

    // Timer counter: a CPU write wins over the count or reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tl_q <= 32'd0;
        end else if (wr_tl) begin
            tl_q <= bus.wdata;
        end else if (wrap) begin
            tl_q <= th_q;
        end else if (tcon_q[0]) begin
            tl_q <= tl_q + 32'd1;
        end
    end

    // Timer control: a same-cycle overflow still sets status over a CPU write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcon_q <= 3'd0;
        end else if (wr_tcon) begin
            tcon_q <= bus.wdata[2:0] | {set_status, 2'b00};
        end else if (set_status) begin
            tcon_q[2] <= 1'b1;
        end
    end

    assign led = led_q;
    assign irq = tcon_q[1] & tcon_q[2];
endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: loads with extension, partial
// stores, faults, timer overflow/collision, aliasing, LED and async reset.
module tb_data_memory_mmio;
    logic       clk;
    logic       reset;
    logic [7:0] led;
    logic       irq;
    int         tests_run;
    int         tests_failed;

    data_memory_mmio_if bus_if ();

    data_memory_mmio #(.ADDR_BITS(8), .MMIO_PAGE(4'h4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .led   (led),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;

    localparam logic [31:0] TH_A   = 32'h4000_0000;
    localparam logic [31:0] TL_A   = 32'h4000_0004;
    localparam logic [31:0] TCON_A = 32'h4000_0008;
    localparam logic [31:0] LED_A  = 32'h4000_000C;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Store: drive strobes between edges, commit on the next rising edge.
    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bus_if.addr      = a;
        bus_if.wdata     = d;
        bus_if.size      = sz;
        bus_if.mem_write = 1'b1;
        @(posedge clk);
        #1;
        bus_if.mem_write = 1'b0;
    endtask

    // Combinational load check; no clock edge consumed.
    task automatic ld(input string tag, input logic [31:0] a, input logic [1:0] sz,
                      input logic u, input logic [31:0] exp);
        bus_if.addr        = a;
        bus_if.size        = sz;
        bus_if.unsigned_ld = u;
        bus_if.mem_read    = 1'b1;
        #1;
        chk(tag, bus_if.rdata, exp);
        bus_if.mem_read    = 1'b0;
        bus_if.unsigned_ld = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run          = 0;
        tests_failed       = 0;
        reset              = 1'b1;
        bus_if.addr        = 32'd0;
        bus_if.wdata       = 32'd0;
        bus_if.mem_read    = 1'b0;
        bus_if.mem_write   = 1'b0;
        bus_if.size        = W;
        bus_if.unsigned_ld = 1'b0;
        #12;
        reset = 1'b0;
        tick();

        chk("rst_rdata", bus_if.rdata, 32'd0);
        chk("rst_misalign", {31'd0, bus_if.misalign}, 32'd0);
        chk("rst_led", {24'd0, led}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        ld("rst_lw10", 32'h10, W, 1'b0, 32'd0);

        st(32'h10, 32'h80FF7F01, W);
        ld("lw10", 32'h10, W, 1'b0, 32'h80FF7F01);
        ld("lb12", 32'h12, B, 1'b0, 32'hFFFFFFFF);
        ld("lbu12", 32'h12, B, 1'b1, 32'h000000FF);
        ld("lb11", 32'h11, B, 1'b0, 32'h0000007F);
        ld("lh12", 32'h12, H, 1'b0, 32'hFFFF80FF);
        ld("lhu12", 32'h12, H, 1'b1, 32'h000080FF);

        st(32'h20, 32'h0, W);
        st(32'h21, 32'h123456AB, B);
        ld("sb21", 32'h20, W, 1'b0, 32'h0000AB00);
        st(32'h22, 32'h0000BEEF, H);
        ld("sh22", 32'h20, W, 1'b0, 32'hBEEFAB00);

        bus_if.addr = 32'h22; bus_if.wdata = 32'hFFFFFFFF; bus_if.size = W;
        bus_if.mem_write = 1'b1;
        #1;
        chk("mis_sw22_flag", {31'd0, bus_if.misalign}, 32'd1);
        tick();
        bus_if.mem_write = 1'b0;
        ld("mis_sw22_mem", 32'h20, W, 1'b0, 32'hBEEFAB00);

        bus_if.addr = 32'h23; bus_if.size = H; bus_if.mem_read = 1'b1;
        #1;
        chk("mis_lh23_flag", {31'd0, bus_if.misalign}, 32'd1);
        chk("mis_lh23_rdata", bus_if.rdata, 32'd0);
        bus_if.mem_read = 1'b0;
        #1;
        chk("mis_idle_flag", {31'd0, bus_if.misalign}, 32'd0);

        bus_if.addr = TH_A; bus_if.wdata = 32'h000000EE; bus_if.size = B;
        bus_if.mem_write = 1'b1;
        #1;
        chk("mis_sb_mmio_flag", {31'd0, bus_if.misalign}, 32'd1);
        tick();
        bus_if.mem_write = 1'b0;
        ld("mis_sb_mmio_th", TH_A, W, 1'b0, 32'd0);

        st(TH_A, 32'hFFFFFFFD, W);
        st(TL_A, 32'hFFFFFFFD, W);
        st(TCON_A, 32'h3, W);
        ld("tmr_start", TL_A, W, 1'b0, 32'hFFFFFFFD);
        tick();
        ld("tmr_e1", TL_A, W, 1'b0, 32'hFFFFFFFE);
        tick();
        ld("tmr_e2", TL_A, W, 1'b0, 32'hFFFFFFFF);
        chk("tmr_e2_irq", {31'd0, irq}, 32'd0);
        tick();
        ld("tmr_e3", TL_A, W, 1'b0, 32'hFFFFFFFD);
        chk("tmr_e3_irq", {31'd0, irq}, 32'd1);
        ld("tmr_e3_tcon", TCON_A, W, 1'b0, 32'h7);
        st(TCON_A, 32'h3, W);
        chk("tmr_clr_irq", {31'd0, irq}, 32'd0);
        ld("tmr_e4", TL_A, W, 1'b0, 32'hFFFFFFFE);
        tick();
        ld("col_pre", TL_A, W, 1'b0, 32'hFFFFFFFF);
        st(TL_A, 32'h5, W);
        ld("col_tl", TL_A, W, 1'b0, 32'h5);
        ld("col_tcon", TCON_A, W, 1'b0, 32'h7);
        chk("col_irq", {31'd0, irq}, 32'd1);
        st(TCON_A, 32'h0, W);
        chk("tcon_off_irq", {31'd0, irq}, 32'd0);

        st(32'h400, 32'hA5A5A5A5, W);
        ld("alias_lw0", 32'h0, W, 1'b0, 32'hA5A5A5A5);

        ld("mmio_unmapped", 32'h4000_0010, W, 1'b0, 32'd0);
        st(LED_A, 32'h000001A5, W);
        chk("led_out", {24'd0, led}, 32'h000000A5);
        ld("led_rd", LED_A, W, 1'b0, 32'h000000A5);

        st(TCON_A, 32'h7, W);
        chk("pre_rst_irq", {31'd0, irq}, 32'd1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        ld("mrst_tl", TL_A, W, 1'b0, 32'd0);
        ld("mrst_tcon", TCON_A, W, 1'b0, 32'd0);
        chk("mrst_led", {24'd0, led}, 32'd0);
        chk("mrst_irq", {31'd0, irq}, 32'd0);
        ld("mrst_lw10", 32'h10, W, 1'b0, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        ld("post_rst_tl", TL_A, W, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
